// File: rtl/zmod_clk_sequencer.sv
// zmod_clk_sequencer: reset / power-down / lock sequencer for the TX clock MMCM.
// Brings the MMCM up with bounded retries and gates downstream resets via ready.
module zmod_clk_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       locked,
    output logic       mmcm_rst,
    output logic       mmcm_pwrdwn,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One shared counter serves the reset pulse, the lock timer and settling.
    localparam int CMAX = max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
    localparam int CW   = $clog2(CMAX + 1) + 1;

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

    logic          sync1_q;
    logic          sync2_q;
    logic          locked_s;

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [3:0]    retry_q;
    logic [3:0]    retry_d;
    logic [3:0]    retry_inc;
    logic [7:0]    llc_q;
    logic [7:0]    llc_d;
    logic          attempt_fail;

    logic          rst_q;
    logic          rst_d;
    logic          pd_q;
    logic          pd_d;
    logic          ready_q;
    logic          ready_d;
    logic          fault_q;
    logic          fault_d;

    assign locked_s  = sync2_q;
    assign retry_inc = retry_q + 4'd1;

    // Two-flop synchronizer bringing MMCM LOCKED into the reference domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= locked;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, counter and retry bookkeeping; enable=0 overrides all.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        llc_d        = llc_q;
        attempt_fail = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    // A lock seen on the timeout cycle takes precedence.
                    if (locked_s) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        attempt_fail = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (!locked_s) begin
                        attempt_fail = 1'b1;
                    end else if (cnt_q == SET_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_RESET;
                        cnt_d   = '0;
                        if (llc_q != 8'hFF) begin
                            llc_d = llc_q + 8'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (attempt_fail) begin
                retry_d = retry_inc;
                cnt_d   = '0;
                state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_RESET;
            end
        end
    end

    // Output decode from the next state so every output is a plain flop.
    always_comb begin
        rst_d   = 1'b1;
        pd_d    = 1'b0;
        ready_d = 1'b0;
        fault_d = 1'b0;
        unique case (state_d)
            ST_IDLE: begin
                pd_d = 1'b1;
            end
            ST_RESET: begin
                rst_d = 1'b1;
            end
            ST_WAIT_LOCK, ST_SETTLE: begin
                rst_d = 1'b0;
            end
            ST_RUN: begin
                rst_d   = 1'b0;
                ready_d = 1'b1;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                pd_d = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs; reset reasserts MMCM RST at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
            llc_q   <= '0;
            rst_q   <= 1'b1;
            pd_q    <= 1'b1;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            llc_q   <= llc_d;
            rst_q   <= rst_d;
            pd_q    <= pd_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    end

    assign mmcm_rst        = rst_q;
    assign mmcm_pwrdwn     = pd_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = llc_q;
    assign state           = state_q;

endmodule
